// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared definitions for the multimode SPI slave: FSM state
//                encoding and the default word shifted out on TX underrun.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Frame-level state of the slave.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

    // All-ones source for the IDLE_FILL default; sliced to DATA_W at use.
    localparam logic [31:0] c_IDLE_FILL_ALL = 32'hFFFF_FFFF;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync
//  Description : Single-bit multi-flop synchronizer with configurable depth
//                and reset value.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset (loads RST_VAL)
//                i_d  - asynchronous input bit
//                o_q  - synchronized output (last stage)
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sync #(
    parameter int   STAGES  = 3,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule : spi_sync
`default_nettype wire

// File: rtl/spi_slave_multimode.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_multimode
//  Description : SPI slave supporting all four CPOL/CPHA modes and MSB/LSB
//                first ordering, oversampled by the system clock. Continuous
//                back-to-back words within one CS frame, TX holding register
//                with underrun fill, RX output register with overrun drop.
//  Ports       : clk, rst                 - system clock / sync reset
//                i_cfg_cpol/cpha/lsb_first - mode, latched at CS fall
//                i_tx_data/valid, o_tx_ready - TX holding-register handshake
//                o_rx_data/valid, i_rx_ready - RX output handshake
//                o_tx_underrun/o_rx_overrun/o_frame_abort - event pulses
//                o_busy                    - frame active
//                i_spi_clk/cs_n/mosi, o_spi_miso/miso_oe - SPI pins
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_multimode
    import spi_pkg::*;
#(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 3,
    parameter logic [DATA_W-1:0] IDLE_FILL   = c_IDLE_FILL_ALL[DATA_W-1:0]
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cfg_cpol,
    input  logic              i_cfg_cpha,
    input  logic              i_cfg_lsb_first,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    input  logic              i_rx_ready,
    output logic              o_tx_underrun,
    output logic              o_rx_overrun,
    output logic              o_frame_abort,
    output logic              o_busy,
    input  logic              i_spi_clk,
    input  logic              i_spi_cs_n,
    input  logic              i_spi_mosi,
    output logic              o_spi_miso,
    output logic              o_spi_miso_oe
);

    localparam int               c_CNT_W = $clog2(DATA_W);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_W - 1);
    localparam logic [2:0]       c_FLUSH = 3'(SYNC_STAGES);

    // ------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------
    logic w_sclk;
    logic w_cs_n;
    logic w_mosi;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk (clk), .rst (rst), .i_d (i_spi_clk),  .o_q (w_sclk)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
        .clk (clk), .rst (rst), .i_d (i_spi_cs_n), .o_q (w_cs_n)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk (clk), .rst (rst), .i_d (i_spi_mosi), .o_q (w_mosi)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic               r_sclk_d;
    logic               r_cs_n_d;
    logic [2:0]         r_flush;
    logic               r_armed;
    spi_state_t         r_state;
    logic               r_cpol;
    logic               r_cpha;
    logic               r_lsb;
    logic [c_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]  r_rx_shift;
    logic [DATA_W-1:0]  r_tx_shift;
    logic               r_miso;
    logic [DATA_W-1:0]  r_hold;
    logic               r_hold_full;
    logic [DATA_W-1:0]  r_rx_data;
    logic               r_rx_valid;
    logic               r_underrun;
    logic               r_overrun;
    logic               r_abort;

    // ------------------------------------------------------------------
    // Edge detection and datapath helpers
    // ------------------------------------------------------------------
    logic              w_rise;
    logic              w_fall;
    logic              w_cs_fall;
    logic              w_cs_rise;
    logic              w_sample;
    logic              w_shift;
    logic              w_last;
    logic              w_tx_write;
    logic              w_load_lsb;
    logic [DATA_W-1:0] w_rx_next;
    logic [DATA_W-1:0] w_load_word;
    logic [DATA_W-1:0] w_load_rev;
    logic [DATA_W-1:0] w_tx_ordered;

    assign w_rise    = w_sclk & ~r_sclk_d;
    assign w_fall    = ~w_sclk & r_sclk_d;
    // A CS fall is honoured only once CS has been genuinely seen high after
    // reset, so a reset in the middle of a frame cannot start a partial one.
    assign w_cs_fall = r_armed & ~w_cs_n & r_cs_n_d;
    assign w_cs_rise = w_cs_n & ~r_cs_n_d;

    // CS rise takes priority over any coincident clock edge.
    assign w_sample = (r_state == ST_ACTIVE) && !w_cs_rise &&
                      ((r_cpol == r_cpha) ? w_rise : w_fall);
    assign w_shift  = (r_state == ST_ACTIVE) && !w_cs_rise &&
                      ((r_cpol == r_cpha) ? w_fall : w_rise);
    assign w_last   = (r_cnt == c_LAST);

    assign w_rx_next = r_lsb ? {w_mosi, r_rx_shift[DATA_W-1:1]}
                             : {r_rx_shift[DATA_W-2:0], w_mosi};

    assign w_tx_write  = i_tx_valid && !r_hold_full;
    assign w_load_word = r_hold_full ? r_hold : IDLE_FILL;
    // At CS fall the config is being latched this very cycle, so use the
    // live input for the first load of the frame.
    assign w_load_lsb  = (r_state == ST_IDLE) ? i_cfg_lsb_first : r_lsb;

    always_comb begin
        w_load_rev = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_load_rev[i] = w_load_word[DATA_W-1-i];
        end
    end

    // The TX shifter always emits from its MSB; LSB-first words are
    // bit-reversed on load.
    assign w_tx_ordered = w_load_lsb ? w_load_rev : w_load_word;

    // ------------------------------------------------------------------
    // Control FSM and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_d    <= 1'b0;
            r_cs_n_d    <= 1'b1;
            r_flush     <= 3'd0;
            r_armed     <= 1'b0;
            r_state     <= ST_IDLE;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_lsb       <= 1'b0;
            r_cnt       <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_miso      <= 1'b0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
            r_overrun   <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_sclk_d   <= w_sclk;
            r_cs_n_d   <= w_cs_n;
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
            r_abort    <= 1'b0;

            // Wait until the cs_n chain holds real samples before arming.
            if (r_flush != c_FLUSH) begin
                r_flush <= r_flush + 3'd1;
            end else if (w_cs_n) begin
                r_armed <= 1'b1;
            end

            if (r_rx_valid && i_rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    r_miso <= 1'b0;
                    if (w_cs_fall) begin
                        r_state    <= ST_ACTIVE;
                        r_cpol     <= i_cfg_cpol;
                        r_cpha     <= i_cfg_cpha;
                        r_lsb      <= i_cfg_lsb_first;
                        r_cnt      <= '0;
                        r_rx_shift <= '0;
                        r_underrun <= !r_hold_full;
                        r_hold_full <= 1'b0;
                        if (i_cfg_cpha) begin
                            // First bit goes out on the first shift edge.
                            r_tx_shift <= w_tx_ordered;
                        end else begin
                            r_miso     <= w_tx_ordered[DATA_W-1];
                            r_tx_shift <= {w_tx_ordered[DATA_W-2:0], 1'b0};
                        end
                    end
                end

                ST_ACTIVE: begin
                    if (w_cs_rise) begin
                        r_state    <= ST_IDLE;
                        r_abort    <= (r_cnt != '0);
                        r_cnt      <= '0;
                        r_rx_shift <= '0;
                        r_tx_shift <= '0;
                        r_miso     <= 1'b0;
                    end else begin
                        if (w_sample) begin
                            r_rx_shift <= w_rx_next;
                            if (w_last) begin
                                r_cnt       <= '0;
                                // Next word is queued whole; the following
                                // shift edge emits its first bit, so there
                                // is no dead bit between words.
                                r_tx_shift  <= w_tx_ordered;
                                r_underrun  <= !r_hold_full;
                                r_hold_full <= 1'b0;
                                if (r_rx_valid && !i_rx_ready) begin
                                    r_overrun <= 1'b1;
                                end else begin
                                    r_rx_data  <= w_rx_next;
                                    r_rx_valid <= 1'b1;
                                end
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                        if (w_shift) begin
                            r_miso     <= r_tx_shift[DATA_W-1];
                            r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase

            // Placed last so a write in the same cycle as a load survives.
            if (w_tx_write) begin
                r_hold      <= i_tx_data;
                r_hold_full <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_tx_ready    = !r_hold_full;
    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_tx_underrun = r_underrun;
    assign o_rx_overrun  = r_overrun;
    assign o_frame_abort = r_abort;
    assign o_busy        = (r_state == ST_ACTIVE);
    assign o_spi_miso    = r_miso;
    assign o_spi_miso_oe = !w_cs_n;

endmodule : spi_slave_multimode
`default_nettype wire

// File: tb/tb_spi_slave_multimode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_multimode
//  Description : Directed self-checking bench for spi_slave_multimode with
//                an SPI master model driving all pins from the system-clock
//                timeline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_multimode;

    localparam int HALF = 8;   // SPI half period in system clocks

    logic       clk = 1'b0;
    logic       rst;
    logic       i_cfg_cpol, i_cfg_cpha, i_cfg_lsb_first;
    logic [7:0] i_tx_data;
    logic       i_tx_valid;
    logic       o_tx_ready;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       i_rx_ready;
    logic       o_tx_underrun, o_rx_overrun, o_frame_abort, o_busy;
    logic       i_spi_clk, i_spi_cs_n, i_spi_mosi;
    logic       o_spi_miso, o_spi_miso_oe;

    int checks = 0;
    int errors = 0;
    int n_unr = 0, n_ovr = 0, n_abort = 0;
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    spi_slave_multimode #(.DATA_W(8), .SYNC_STAGES(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_cfg_cpol     (i_cfg_cpol),
        .i_cfg_cpha     (i_cfg_cpha),
        .i_cfg_lsb_first(i_cfg_lsb_first),
        .i_tx_data      (i_tx_data),
        .i_tx_valid     (i_tx_valid),
        .o_tx_ready     (o_tx_ready),
        .o_rx_data      (o_rx_data),
        .o_rx_valid     (o_rx_valid),
        .i_rx_ready     (i_rx_ready),
        .o_tx_underrun  (o_tx_underrun),
        .o_rx_overrun   (o_rx_overrun),
        .o_frame_abort  (o_frame_abort),
        .o_busy         (o_busy),
        .i_spi_clk      (i_spi_clk),
        .i_spi_cs_n     (i_spi_cs_n),
        .i_spi_mosi     (i_spi_mosi),
        .o_spi_miso     (o_spi_miso),
        .o_spi_miso_oe  (o_spi_miso_oe)
    );

    // Event monitor on the inactive edge.
    always @(negedge clk) begin
        if (o_rx_valid && i_rx_ready) rx_q.push_back(o_rx_data);
        if (o_tx_underrun) n_unr++;
        if (o_rx_overrun)  n_ovr++;
        if (o_frame_abort) n_abort++;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tx_write(input logic [7:0] d);
        i_tx_data  = d;
        i_tx_valid = 1'b1;
        tick(1);
        i_tx_valid = 1'b0;
    endtask

    task automatic set_mode(input logic cpol, input logic cpha, input logic lsb);
        i_cfg_cpol      = cpol;
        i_cfg_cpha      = cpha;
        i_cfg_lsb_first = lsb;
        i_spi_clk       = cpol;
        tick(2 * HALF);
    endtask

    task automatic cs_assert();
        i_spi_cs_n = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_deassert();
        tick(HALF);
        i_spi_cs_n = 1'b1;
        tick(2 * HALF);
    endtask

    // Master: shifts nbits of mo out, captures miso at its sample edge.
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            int idx;
            idx = i_cfg_lsb_first ? i : 7 - i;
            if (!i_cfg_cpha) begin
                i_spi_mosi = mo[idx];
                tick(HALF);
                i_spi_clk = ~i_spi_clk;
                mi[idx]   = o_spi_miso;
                tick(HALF);
                i_spi_clk = ~i_spi_clk;
            end else begin
                i_spi_clk  = ~i_spi_clk;
                i_spi_mosi = mo[idx];
                tick(HALF);
                i_spi_clk = ~i_spi_clk;
                mi[idx]   = o_spi_miso;
                tick(HALF);
            end
        end
    endtask

    initial begin
        logic [7:0] mi, mi2;
        int q0, u0, o0, a0;

        rst = 1'b1;
        i_cfg_cpol = 0; i_cfg_cpha = 0; i_cfg_lsb_first = 0;
        i_tx_data = 8'h00; i_tx_valid = 0; i_rx_ready = 1;
        i_spi_clk = 0; i_spi_cs_n = 1; i_spi_mosi = 0;
        tick(3);

        // Reset state
        check("rst_tx_ready", 32'(o_tx_ready), 1);
        check("rst_rx_valid", 32'(o_rx_valid), 0);
        check("rst_rx_data",  32'(o_rx_data), 0);
        check("rst_busy",     32'(o_busy), 0);
        check("rst_miso",     32'(o_spi_miso), 0);
        check("rst_miso_oe",  32'(o_spi_miso_oe), 0);
        check("rst_events",   32'({o_tx_underrun, o_rx_overrun, o_frame_abort}), 0);
        rst = 1'b0;
        tick(10);

        // Mode 0, TX 0xA5, master sends 0x3C
        set_mode(0, 0, 0);
        tx_write(8'hA5);
        check("m0_ready_full", 32'(o_tx_ready), 0);
        q0 = rx_q.size();
        cs_assert();
        check("m0_busy", 32'(o_busy), 1);
        check("m0_oe",   32'(o_spi_miso_oe), 1);
        xfer(8'h3C, 8, mi);
        cs_deassert();
        check("m0_miso",     32'(mi), 32'hA5);
        check("m0_rx_count", rx_q.size() - q0, 1);
        check("m0_rx_data",  32'(rx_q[q0]), 32'h3C);
        check("m0_idle_busy", 32'(o_busy), 0);
        check("m0_idle_miso", 32'(o_spi_miso), 0);

        // Mode 3, two back-to-back words; third write covers the final load
        set_mode(1, 1, 0);
        tx_write(8'hC3);
        q0 = rx_q.size(); u0 = n_unr;
        cs_assert();
        tx_write(8'h5A);
        xfer(8'h12, 8, mi);
        tx_write(8'h00);
        xfer(8'h34, 8, mi2);
        cs_deassert();
        check("m3_miso_w0", 32'(mi), 32'hC3);
        check("m3_miso_w1", 32'(mi2), 32'h5A);
        check("m3_rx_count", rx_q.size() - q0, 2);
        check("m3_rx_w0", 32'(rx_q[q0]), 32'h12);
        check("m3_rx_w1", 32'(rx_q[q0 + 1]), 32'h34);
        check("m3_no_underrun", n_unr - u0, 0);

        // Mode 1, LSB first, TX 0x01, master sends 0xB4
        set_mode(0, 1, 1);
        tx_write(8'h01);
        q0 = rx_q.size();
        cs_assert();
        xfer(8'hB4, 8, mi);
        cs_deassert();
        check("m1lsb_first_bit", 32'(mi[0]), 1);
        check("m1lsb_miso", 32'(mi), 32'h01);
        check("m1lsb_rx",   32'(rx_q[q0]), 32'hB4);

        // Empty holding register at CS fall -> fill pattern, one underrun
        set_mode(0, 0, 0);
        u0 = n_unr;
        cs_assert();
        tx_write(8'h77);
        xfer(8'h00, 8, mi);
        cs_deassert();
        check("unr_miso",  32'(mi), 32'hFF);
        check("unr_count", n_unr - u0, 1);

        // RX not ready over two words -> first word kept, one overrun
        i_rx_ready = 1'b0;
        q0 = rx_q.size(); o0 = n_ovr;
        cs_assert();
        xfer(8'h11, 8, mi);
        xfer(8'h22, 8, mi);
        cs_deassert();
        check("ovr_count",    n_ovr - o0, 1);
        check("ovr_valid",    32'(o_rx_valid), 1);
        check("ovr_data",     32'(o_rx_data), 32'h11);
        i_rx_ready = 1'b1;
        tick(2);
        check("ovr_drain_valid", 32'(o_rx_valid), 0);
        check("ovr_drain_data",  32'(rx_q[q0]), 32'h11);

        // CS raised after 5 bits -> abort, no word, holding register kept
        q0 = rx_q.size(); a0 = n_abort;
        cs_assert();
        tx_write(8'h99);
        xfer(8'hFF, 5, mi);
        cs_deassert();
        check("abort_count", n_abort - a0, 1);
        check("abort_no_rx", rx_q.size() - q0, 0);
        check("abort_hold_kept", 32'(o_tx_ready), 0);
        check("abort_busy", 32'(o_busy), 0);

        // Reset with CS low mid-frame: silent abort, stay disarmed
        a0 = n_abort;
        cs_assert();
        xfer(8'h0F, 3, mi);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        check("rstmid_busy",  32'(o_busy), 0);
        check("rstmid_ready", 32'(o_tx_ready), 1);
        xfer(8'hAA, 8, mi);
        tick(HALF);
        check("rstmid_no_frame", 32'(o_busy), 0);
        check("rstmid_no_rx",    rx_q.size() - q0, 0);
        check("rstmid_miso",     32'(o_spi_miso), 0);
        check("rstmid_no_abort", n_abort - a0, 0);
        i_spi_cs_n = 1'b1;
        tick(2 * HALF);
        cs_assert();
        check("rearm_busy", 32'(o_busy), 1);
        cs_deassert();
        check("rearm_no_abort", n_abort - a0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_spi_slave_multimode
`default_nettype wire
